avl_ddr_responder: RTL and testbench
====================================

Name: avl_ddr_responder

Overview:
- Avalon-MM responder that models the DDR3 controller's local interface: synthesizable and usable on-board or in simulation.
- Sits on the other side of the team's `avl_*` traffic generators/testers, in place of the hard controller; lets the initiators be exercised without the PHY.
- Emits a calibration sequence, accepts single/burst writes into on-chip RAM with byte enables, and returns read bursts after a fixed latency.

Parameters:
- ADDR_W, 26, width of avl_addr (word address).
- DATA_W, 64, data width; BE_W = DATA_W/8.
- MEM_AW, 8, log2 of internal RAM depth in words; address uses avl_addr[MEM_AW-1:0].
- RD_LAT, 4, cycles from read-command acceptance to first avl_rdata_valid (min 2).
- CAL_CYCLES, 64, cycles after reset before calibration completes.
- CAL_FAIL, 0, 1 = report calibration failure instead of success.

Ports:
- afi_clk  in  1  sole clock.
- rstn  in  1  asynchronous active-low reset.
- avl_ready  out  1  waitrequest_n; command/beat accepted only when high.
- avl_burstbegin  in  1  first beat of a command.
- avl_addr  in  ADDR_W  word address of the first beat.
- avl_size  in  3  burstcount.
- avl_write_req  in  1  write beat.
- avl_wdata  in  DATA_W  write data.
- avl_be  in  BE_W  byte enables.
- avl_read_req  in  1  read command.
- avl_rdata_valid  out  1  read beat valid.
- avl_rdata  out  DATA_W  read data.
- local_init_done  out  1  init/cal finished.
- local_cal_success  out  1  calibration passed.
- local_cal_fail  out  1  calibration failed.
- proto_err  out  1  one-cycle pulse on protocol violation.

Behaviour:
- Reset values:
  - All outputs 0; avl_rdata is 0.
  - State CAL, counters 0.
  - RAM contents are not cleared.
- Reset asserted mid-burst: abort immediately and return to CAL; no further avl_rdata_valid.
- States:
  - CAL: avl_ready=0; count CAL_CYCLES; on terminal count set local_init_done=1, and set local_cal_success=1 (or local_cal_fail=1 if CAL_FAIL); next IDLE, or FAILED when CAL_FAIL.
  - FAILED: terminal; avl_ready=0 forever.
  - IDLE: avl_ready=1.
    - write_req&ready: write beat to RAM at addr (byte-masked by avl_be); latch addr+1 and remaining = size-1. If remaining>0, go WBURST.
    - read_req&ready: latch addr and count=size; go RWAIT.
  - WBURST: avl_ready=1. Each write_req beat writes at the latched addr, increments addr, decrements remaining; at 0 return to IDLE. Cycles with write_req=0 simply hold state.
  - RWAIT: avl_ready=0; wait RD_LAT-1 cycles total after acceptance, then go RDATA.
  - RDATA: avl_ready=0; avl_rdata_valid=1 for count consecutive cycles, one word per cycle from incrementing addr; then IDLE.
- Read latency:
  - First valid appears exactly RD_LAT cycles after the accepting edge.
  - The RAM read is registered (1 cycle), so prefetch is issued one cycle early.
- Address wrap: the internal address uses only the low MEM_AW bits, so a burst crossing the top of RAM wraps to 0.
- avl_size==0 is treated as 1 and raises proto_err.
- write_req and read_req both high in IDLE: the write is accepted, the read is ignored, and proto_err pulses.
- avl_burstbegin:
  - Low with a command in IDLE: the command is still accepted and proto_err pulses.
  - High in WBURST: the burst is aborted, proto_err pulses, and the beat is treated as a new IDLE command.
- Read-after-write to the same address returns the new data (a write completes before the next command is accepted).
- No outstanding reads: one read in flight at a time.

Optional Feature:
- Macro: AVL_RESP_BACKPRESSURE_EN.
- When defined:
  - A 16-bit LFSR (seed 16'hACE1, advances every cycle outside CAL) forces avl_ready=0 in IDLE/WBURST whenever lfsr[1:0]==2'b00.
  - Beats presented while avl_ready=0 are not accepted.
- When undefined: avl_ready is exactly as in Behaviour and no LFSR is present.

Decomposition:
- Package avl_resp_pkg:
  - state encoding (CAL, FAILED, IDLE, WBURST, RWAIT, RDATA).
  - LFSR seed/taps constants.
  - default RD_LAT/CAL_CYCLES.
- Sub-module avl_resp_ram:
  - one write port with byte enables, one registered read port.
  - depth 2**MEM_AW, width DATA_W.

Test Plan:
- Reset, then idle 100 cycles → local_init_done and local_cal_success rise at cycle 64, avl_ready=1 from cycle 65; with CAL_FAIL=1, local_cal_fail=1 and avl_ready stays 0.
- Write size=1 at addr 0 with data 64'hf0f0f0f0_f0f0f0f0, be=8'hff, then read size=1 at addr 0 → single avl_rdata_valid exactly 4 cycles after read acceptance, data 64'hf0f0f0f0_f0f0f0f0.
- Write burst size=4 at addr 8'hFE (data 1,2,3,4), then read size=4 at 8'hFE → beats 1,2,3,4 back-to-back; addresses FE, FF, 00, 01 (wrap).
- Write 64'h0 with be=8'hff, then 64'hFFFF_FFFF_FFFF_FFFF with be=8'h0F to addr 5, then read → 64'h0000_0000_FFFF_FFFF.
- read_req and write_req together; size=0; burstbegin=0 → proto_err one-cycle pulse each time; write wins; size-0 read returns one beat.
- Assert rstn low during RDATA beat 2 of 4 → avl_rdata_valid drops immediately; CAL restarts; RAM data from before reset is still readable afterwards.

Source files
------------

// File: rtl/avl_resp_pkg.sv
// Shared types and constants for the Avalon-MM DDR controller stand-in (avl_ddr_responder).
package avl_resp_pkg;

  typedef enum logic [2:0] {
    ST_CAL    = 3'd0,
    ST_FAILED = 3'd1,
    ST_IDLE   = 3'd2,
    ST_WBURST = 3'd3,
    ST_RWAIT  = 3'd4,
    ST_RDATA  = 3'd5
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int DEF_RD_LAT     = 4;
  localparam int DEF_CAL_CYCLES = 64;

  // Galois form of the maximal-length x^16+x^14+x^13+x^11+1 polynomial.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/avl_resp_ram.sv
// Byte-maskable single-write / registered-read RAM backing the responder (contents never reset).
module avl_resp_ram #(
  parameter int DATA_W = 64,
  parameter int MEM_AW = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  we_i,
  input  logic [MEM_AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DATA_W/8-1:0]   be_i,
  input  logic                  re_i,
  input  logic [MEM_AW-1:0]     raddr_i,
  output logic [DATA_W-1:0]     rdata_o
);

  localparam int BE_W = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [2**MEM_AW];
  logic [DATA_W-1:0] rdata_q;

  // Byte-lane write into the array.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be_i[b]) begin
          mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  // Registered read port; only the output register is reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end else begin
      rdata_q <= rdata_q;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/avl_ddr_responder.sv
// Avalon-MM responder standing in for the DDR3 controller local interface.
// Define AVL_RESP_BACKPRESSURE_EN to add LFSR-driven avl_ready backpressure.
module avl_ddr_responder
  import avl_resp_pkg::*;
#(
  parameter int ADDR_W     = 26,
  parameter int DATA_W     = 64,
  parameter int MEM_AW     = 8,
  parameter int RD_LAT     = DEF_RD_LAT,
  parameter int CAL_CYCLES = DEF_CAL_CYCLES,
  parameter int CAL_FAIL   = 0
) (
  input  logic                  afi_clk,
  input  logic                  rstn,
  output logic                  avl_ready,
  input  logic                  avl_burstbegin,
  input  logic [ADDR_W-1:0]     avl_addr,
  input  logic [2:0]            avl_size,
  input  logic                  avl_write_req,
  input  logic [DATA_W-1:0]     avl_wdata,
  input  logic [DATA_W/8-1:0]   avl_be,
  input  logic                  avl_read_req,
  output logic                  avl_rdata_valid,
  output logic [DATA_W-1:0]     avl_rdata,
  output logic                  local_init_done,
  output logic                  local_cal_success,
  output logic                  local_cal_fail,
  output logic                  proto_err
);

  localparam int CAL_W = $clog2(CAL_CYCLES + 1);
  localparam int LAT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;

  state_e            state_q, state_d;
  logic [CAL_W-1:0]  cal_cnt_q, cal_cnt_d;
  logic              init_done_q, init_done_d;
  logic              cal_ok_q, cal_ok_d;
  logic              cal_bad_q, cal_bad_d;
  logic              ready_q, ready_d;
  logic [MEM_AW-1:0] wr_addr_q, wr_addr_d;
  logic [MEM_AW-1:0] rd_addr_q, rd_addr_d;
  logic [2:0]        rem_q, rem_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;

  logic              take_cmd_s;
  logic              ram_we_s;
  logic [MEM_AW-1:0] ram_waddr_s;
  logic              ram_re_s;
  logic [2:0]        eff_size_s;
  logic              bp_ok_s;
  logic              unused_addr_hi;

  assign eff_size_s     = (avl_size == 3'd0) ? 3'd1 : avl_size;
  assign unused_addr_hi = ^avl_addr[ADDR_W-1:MEM_AW];

`ifdef AVL_RESP_BACKPRESSURE_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d  = (state_q == ST_CAL) ? lfsr_q : lfsr_step(lfsr_q);
  assign bp_ok_s = (lfsr_d[1:0] != 2'b00);

  // Backpressure pattern generator, frozen during calibration.
  always_ff @(posedge afi_clk or negedge rstn) begin
    if (!rstn) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign bp_ok_s = 1'b1;
`endif

  // Next-state logic: calibration, command decode, burst and read sequencing.
  always_comb begin
    state_d     = state_q;
    cal_cnt_d   = cal_cnt_q;
    init_done_d = init_done_q;
    cal_ok_d    = cal_ok_q;
    cal_bad_d   = cal_bad_q;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    rem_d       = rem_q;
    lat_d       = lat_q;
    valid_d     = 1'b0;
    perr_d      = 1'b0;
    take_cmd_s  = 1'b0;
    ram_we_s    = 1'b0;
    ram_waddr_s = wr_addr_q;
    ram_re_s    = 1'b0;

    case (state_q)
      ST_CAL: begin
        // Result flags rise one cycle before the state leaves CAL.
        if (init_done_q) begin
          state_d = (CAL_FAIL != 0) ? ST_FAILED : ST_IDLE;
        end else if (cal_cnt_q == CAL_W'(CAL_CYCLES - 1)) begin
          init_done_d = 1'b1;
          cal_ok_d    = (CAL_FAIL == 0);
          cal_bad_d   = (CAL_FAIL != 0);
        end else begin
          cal_cnt_d = cal_cnt_q + CAL_W'(1);
        end
      end
      ST_FAILED: begin
        state_d = ST_FAILED;
      end
      ST_IDLE: begin
        take_cmd_s = ready_q && (avl_write_req || avl_read_req);
      end
      ST_WBURST: begin
        if (ready_q && avl_burstbegin && (avl_write_req || avl_read_req)) begin
          take_cmd_s = 1'b1;
          perr_d     = 1'b1;
        end else if (ready_q && avl_write_req) begin
          ram_we_s  = 1'b1;
          wr_addr_d = wr_addr_q + MEM_AW'(1);
          rem_d     = rem_q - 3'd1;
          state_d   = (rem_q == 3'd1) ? ST_IDLE : ST_WBURST;
        end else begin
          state_d = ST_WBURST;
        end
      end
      ST_RWAIT: begin
        if (lat_q == LAT_W'(RD_LAT - 2)) begin
          state_d = ST_RDATA;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      ST_RDATA: begin
        // RAM read issued here surfaces as a valid beat next cycle.
        ram_re_s  = 1'b1;
        valid_d   = 1'b1;
        rd_addr_d = rd_addr_q + MEM_AW'(1);
        rem_d     = rem_q - 3'd1;
        state_d   = (rem_q == 3'd1) ? ST_IDLE : ST_RDATA;
      end
      default: begin
        state_d = ST_CAL;
      end
    endcase

    if (take_cmd_s) begin
      perr_d = perr_d | (avl_size == 3'd0) | ~avl_burstbegin | (avl_write_req & avl_read_req);
      if (avl_write_req) begin
        ram_we_s    = 1'b1;
        ram_waddr_s = avl_addr[MEM_AW-1:0];
        wr_addr_d   = avl_addr[MEM_AW-1:0] + MEM_AW'(1);
        rem_d       = eff_size_s - 3'd1;
        state_d     = (eff_size_s == 3'd1) ? ST_IDLE : ST_WBURST;
      end else begin
        rd_addr_d = avl_addr[MEM_AW-1:0];
        rem_d     = eff_size_s;
        lat_d     = '0;
        state_d   = ST_RWAIT;
      end
    end else begin
      perr_d = perr_d;
    end

    ready_d = ((state_d == ST_IDLE) || (state_d == ST_WBURST)) && bp_ok_s;
  end

  // State and output registers.
  always_ff @(posedge afi_clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_CAL;
      cal_cnt_q   <= '0;
      init_done_q <= 1'b0;
      cal_ok_q    <= 1'b0;
      cal_bad_q   <= 1'b0;
      ready_q     <= 1'b0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      rem_q       <= 3'd0;
      lat_q       <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cal_cnt_q   <= cal_cnt_d;
      init_done_q <= init_done_d;
      cal_ok_q    <= cal_ok_d;
      cal_bad_q   <= cal_bad_d;
      ready_q     <= ready_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      rem_q       <= rem_d;
      lat_q       <= lat_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
    end
  end

  avl_resp_ram #(
    .DATA_W (DATA_W),
    .MEM_AW (MEM_AW)
  ) u_ram (
    .clk_i   (afi_clk),
    .rst_n_i (rstn),
    .we_i    (ram_we_s),
    .waddr_i (ram_waddr_s),
    .wdata_i (avl_wdata),
    .be_i    (avl_be),
    .re_i    (ram_re_s),
    .raddr_i (rd_addr_q),
    .rdata_o (avl_rdata)
  );

  assign avl_ready         = ready_q;
  assign avl_rdata_valid   = valid_q;
  assign local_init_done   = init_done_q;
  assign local_cal_success = cal_ok_q;
  assign local_cal_fail    = cal_bad_q;
  assign proto_err         = perr_q;

endmodule

// File: tb/tb_avl_ddr_responder.sv
// Self-checking bench for avl_ddr_responder: transaction-level memory model plus directed vectors.
module tb_avl_ddr_responder;

  localparam int RD_LAT = 4;

  logic        afi_clk = 1'b0;
  logic        rstn = 1'b0;
  logic        avl_burstbegin = 1'b0;
  logic [25:0] avl_addr = '0;
  logic [2:0]  avl_size = '0;
  logic        avl_write_req = 1'b0;
  logic [63:0] avl_wdata = '0;
  logic [7:0]  avl_be = '0;
  logic        avl_read_req = 1'b0;

  logic        avl_ready, avl_rdata_valid, local_init_done, local_cal_success, local_cal_fail, proto_err;
  logic [63:0] avl_rdata;
  logic        f_ready, f_valid, f_done, f_ok, f_bad, f_perr;
  logic [63:0] f_rdata;

  avl_ddr_responder dut (
    .afi_clk(afi_clk), .rstn(rstn), .avl_ready(avl_ready), .avl_burstbegin(avl_burstbegin),
    .avl_addr(avl_addr), .avl_size(avl_size), .avl_write_req(avl_write_req), .avl_wdata(avl_wdata),
    .avl_be(avl_be), .avl_read_req(avl_read_req), .avl_rdata_valid(avl_rdata_valid),
    .avl_rdata(avl_rdata), .local_init_done(local_init_done), .local_cal_success(local_cal_success),
    .local_cal_fail(local_cal_fail), .proto_err(proto_err)
  );

  avl_ddr_responder #(.CAL_FAIL(1)) dut_fail (
    .afi_clk(afi_clk), .rstn(rstn), .avl_ready(f_ready), .avl_burstbegin(avl_burstbegin),
    .avl_addr(avl_addr), .avl_size(avl_size), .avl_write_req(avl_write_req), .avl_wdata(avl_wdata),
    .avl_be(avl_be), .avl_read_req(avl_read_req), .avl_rdata_valid(f_valid),
    .avl_rdata(f_rdata), .local_init_done(f_done), .local_cal_success(f_ok),
    .local_cal_fail(f_bad), .proto_err(f_perr)
  );

  always #5 afi_clk = ~afi_clk;

  int cyc = 0;
  always @(posedge afi_clk) cyc <= cyc + 1;

  int n_cmp = 0, n_fail = 0, perr_seen = 0, last_exp = 0;
  bit chk_en = 1'b0;
  bit exp_valid[int];
  logic [63:0] exp_data[int];
  bit exp_perr[int];
  logic [63:0] obs_q[$];
  int obs_cyc[$];

  logic [63:0] mdl_mem [256];
  int wb_rem = 0;
  logic [7:0] wb_addr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void mwrite(input logic [7:0] a, input logic [63:0] d, input logic [7:0] be);
    for (int b = 0; b < 8; b++) if (be[b]) mdl_mem[a][b*8 +: 8] = d[b*8 +: 8];
  endfunction

  // Transaction model: what one accepted beat does, stated in interface terms.
  function automatic void model_accept(input int acc, input bit wr, input bit rd, input bit bb,
                                       input logic [25:0] addr, input logic [2:0] size,
                                       input logic [63:0] wd, input logic [7:0] be);
    int eff;
    bit perr;
    if (wb_rem > 0 && !bb) begin
      if (wr) begin
        mwrite(wb_addr, wd, be);
        wb_addr = wb_addr + 8'd1;
        wb_rem--;
      end
    end else begin
      eff  = (size == 3'd0) ? 1 : int'(size);
      perr = (size == 3'd0) || !bb || (wr && rd) || (wb_rem > 0);
      wb_rem = 0;
      if (wr) begin
        mwrite(addr[7:0], wd, be);
        wb_addr = addr[7:0] + 8'd1;
        wb_rem  = eff - 1;
      end else if (rd) begin
        for (int i = 0; i < eff; i++) begin
          exp_valid[acc + RD_LAT + i] = 1'b1;
          exp_data[acc + RD_LAT + i]  = mdl_mem[addr[7:0] + 8'(i)];
          if (acc + RD_LAT + i > last_exp) last_exp = acc + RD_LAT + i;
        end
      end
      if (perr) begin
        exp_perr[acc] = 1'b1;
        if (acc > last_exp) last_exp = acc;
      end
    end
  endfunction

  // Per-cycle comparison of the read and error outputs against the model.
  always @(negedge afi_clk) begin
    if (chk_en) begin
      logic ev;
      ev = exp_valid.exists(cyc) ? 1'b1 : 1'b0;
      check("rdata_valid", 64'(avl_rdata_valid), 64'(ev));
      if (ev) check("rdata", avl_rdata, exp_data[cyc]);
      check("proto_err", 64'(proto_err), 64'(exp_perr.exists(cyc) ? 1'b1 : 1'b0));
      if (avl_rdata_valid) begin
        obs_q.push_back(avl_rdata);
        obs_cyc.push_back(cyc);
      end
      if (proto_err) perr_seen++;
    end
  end

  task automatic send(input bit wr, input bit rd, input bit bb, input logic [25:0] addr,
                      input logic [2:0] size, input logic [63:0] wd, input logic [7:0] be,
                      output int acc);
    bit done;
    done = 1'b0;
    acc  = -1;
    avl_write_req = wr; avl_read_req = rd; avl_burstbegin = bb;
    avl_addr = addr; avl_size = size; avl_wdata = wd; avl_be = be;
    for (int t = 0; t < 200 && !done; t++) begin
      if (avl_ready) begin
        acc = cyc + 1;
        model_accept(acc, wr, rd, bb, addr, size, wd, be);
        done = 1'b1;
      end
      @(negedge afi_clk);
    end
    if (!done) check("send_timeout", 64'd0, 64'd1);
    avl_write_req = 1'b0; avl_read_req = 1'b0; avl_burstbegin = 1'b0;
    avl_size = 3'd0; avl_be = 8'h00;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (cyc > last_exp && avl_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge afi_clk);
    end
    if (!ok) check("idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic rd(input logic [25:0] addr, input logic [2:0] size, output int acc);
    obs_q.delete();
    obs_cyc.delete();
    send(1'b0, 1'b1, 1'b1, addr, size, 64'd0, 8'h00, acc);
    wait_idle();
  endtask

  task automatic wr(input bit bb, input logic [25:0] addr, input logic [2:0] size,
                    input logic [63:0] wd, input logic [7:0] be);
    int acc;
    send(1'b1, 1'b0, bb, addr, size, wd, be, acc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, p0, tgt;
    repeat (3) @(negedge afi_clk);
    check("rst_ready", 64'(avl_ready), 64'd0);
    check("rst_valid", 64'(avl_rdata_valid), 64'd0);
    check("rst_rdata", avl_rdata, 64'd0);
    check("rst_done", 64'({local_init_done, local_cal_success, local_cal_fail, proto_err}), 64'd0);
    rstn = 1'b1;
    chk_en = 1'b1;

    // Calibration timeline, counted in clock edges since reset release.
    for (int k = 1; k <= 100; k++) begin
      @(negedge afi_clk);
      if (k >= 60 && k <= 70) begin
        check("cal_done", 64'(local_init_done), 64'(k >= 64));
        check("cal_success", 64'(local_cal_success), 64'(k >= 64));
        check("cal_fail_flag", 64'(local_cal_fail), 64'd0);
        check("cal_ready", 64'(avl_ready), 64'(k >= 65));
      end
      if (k >= 60) begin
        check("calf_fail", 64'(f_bad), 64'(k >= 64));
        check("calf_success", 64'(f_ok), 64'd0);
        check("calf_ready", 64'(f_ready), 64'd0);
      end
    end

    // Single write then single read with fixed latency.
    wr(1'b1, 26'h0, 3'd1, 64'hf0f0f0f0_f0f0f0f0, 8'hFF);
    rd(26'h0, 3'd1, acc);
    check("t2_beats", 64'(obs_q.size()), 64'd1);
    if (obs_q.size() == 1) begin
      check("t2_data", obs_q[0], 64'hf0f0f0f0_f0f0f0f0);
      check("t2_latency", 64'(obs_cyc[0] - acc), 64'd4);
    end

    // Burst write/read wrapping over the top of RAM.
    wr(1'b1, 26'hFE, 3'd4, 64'd1, 8'hFF);
    for (int i = 2; i <= 4; i++) wr(1'b0, 26'h0, 3'd0, 64'(i), 8'hFF);
    rd(26'hFE, 3'd4, acc);
    check("t3_beats", 64'(obs_q.size()), 64'd4);
    if (obs_q.size() == 4) begin
      for (int i = 0; i < 4; i++) check("t3_data", obs_q[i], 64'(i + 1));
      check("t3_b2b", 64'(obs_cyc[3] - obs_cyc[0]), 64'd3);
    end

    // Byte-enable merge.
    wr(1'b1, 26'h5, 3'd1, 64'h0, 8'hFF);
    wr(1'b1, 26'h5, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    rd(26'h5, 3'd1, acc);
    if (obs_q.size() == 1) check("t4_data", obs_q[0], 64'h0000_0000_FFFF_FFFF);
    else check("t4_beats", 64'(obs_q.size()), 64'd1);

    // Protocol violations.
    p0 = perr_seen;
    obs_q.delete();
    send(1'b1, 1'b1, 1'b1, 26'h10, 3'd1, 64'hAA, 8'hFF, acc);
    wait_idle();
    check("t5_both_perr", 64'(perr_seen - p0), 64'd1);
    check("t5_both_noread", 64'(obs_q.size()), 64'd0);
    send(1'b0, 1'b1, 1'b1, 26'h10, 3'd0, 64'd0, 8'h00, acc);
    obs_q.delete();
    wait_idle();
    check("t5_size0_perr", 64'(perr_seen - p0), 64'd2);
    if (obs_q.size() == 1) check("t5_size0_data", obs_q[0], 64'hAA);
    else check("t5_size0_beats", 64'(obs_q.size()), 64'd1);
    wr(1'b0, 26'h20, 3'd1, 64'hBB, 8'hFF);
    rd(26'h20, 3'd1, acc);
    check("t5_bb0_perr", 64'(perr_seen - p0), 64'd3);
    if (obs_q.size() == 1) check("t5_bb0_data", obs_q[0], 64'hBB);
    wr(1'b1, 26'h30, 3'd4, 64'h31, 8'hFF);
    wr(1'b0, 26'h0, 3'd0, 64'h32, 8'hFF);
    wr(1'b1, 26'h40, 3'd1, 64'h41, 8'hFF);
    rd(26'h30, 3'd2, acc);
    check("t5_abort_perr", 64'(perr_seen - p0), 64'd4);
    if (obs_q.size() == 2) check("t5_abort_b1", obs_q[1], 64'h32);
    rd(26'h40, 3'd1, acc);
    if (obs_q.size() == 1) check("t5_abort_new", obs_q[0], 64'h41);
    else check("t5_abort_beats", 64'(obs_q.size()), 64'd1);

    // Reset in the middle of a read burst.
    wr(1'b1, 26'h60, 3'd4, 64'hA0, 8'hFF);
    for (int i = 1; i < 4; i++) wr(1'b0, 26'h0, 3'd0, 64'hA0 + 64'(i), 8'hFF);
    wait_idle();
    send(1'b0, 1'b1, 1'b1, 26'h60, 3'd4, 64'd0, 8'h00, acc);
    tgt = acc + RD_LAT + 1;
    while (cyc < tgt) begin
      @(posedge afi_clk);
      #1;
    end
    check("t6_beat2_valid", 64'(avl_rdata_valid), 64'd1);
    check("t6_beat2_data", avl_rdata, 64'hA1);
    rstn = 1'b0;
    exp_valid.delete();
    exp_data.delete();
    exp_perr.delete();
    wb_rem = 0;
    #1;
    check("t6_valid_drop", 64'(avl_rdata_valid), 64'd0);
    check("t6_done_drop", 64'(local_init_done), 64'd0);
    repeat (3) @(negedge afi_clk);
    rstn = 1'b1;
    last_exp = cyc;
    wait_idle();
    rd(26'h60, 3'd1, acc);
    if (obs_q.size() == 1) check("t6_keep_60", obs_q[0], 64'hA0);
    else check("t6_beats", 64'(obs_q.size()), 64'd1);
    rd(26'h5, 3'd1, acc);
    if (obs_q.size() == 1) check("t6_keep_05", obs_q[0], 64'h0000_0000_FFFF_FFFF);
    rd(26'h0, 3'd1, acc);
    if (obs_q.size() == 1) check("t6_keep_00", obs_q[0], 64'd3);

    repeat (5) @(negedge afi_clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
